// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU-to-memory access controller with lane steering, extension and timeout
//
// Purpose: accepts one CPU load/store at a time, checks alignment and size, drives a simple
// chip-select memory port with byte enables and lane-replicated write data, extracts and
// zero/sign-extends read data, and gives up with an error after MAX_WAIT access cycles.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_*           CPU request (valid/ready handshake, we, size, signed, addr, wdata)
//   rsp_*           one-cycle response strobe with read data and error flag
//   mem_cs/we/oe    memory strobes, only asserted in the access phase
//   mem_addr/be     lane-aligned address and byte enables
//   mem_wdata       write data replicated across all byte lanes
//   mem_rdata/ready memory read data and completion handshake
module mem_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_cs,
  output logic                mem_we,
  output logic                mem_oe,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nx;
  logic                we_q, signed_q, err_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [7:0]          wait_cnt;
  logic                req_bad, timeout;
  logic [LB-1:0]       lane;
  logic [NB-1:0]       be_mask;
  logic [DATA_W-1:0]   rd_sh, fmask, rd_ext;
  logic                rd_msb;

  assign lane    = addr_q[LB-1:0];
  assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  // Alignment/size check on the live request, so an illegal one skips ACCESS entirely.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b00: req_bad = 1'b0;
      2'b01: req_bad = req_addr[0];
      2'b10: req_bad = |req_addr[1:0];
      default: req_bad = (DATA_W == 32) ? 1'b1 : |req_addr[2:0];
    endcase
  end

  // Byte enables, write replication and read field mask all derive from the captured size.
  always_comb begin
    be_mask   = '0;
    mem_wdata = wdata_q;
    fmask     = '1;
    rd_sh     = mem_rdata >> {lane, 3'b000};
    rd_msb    = rd_sh[DATA_W-1];
    case (size_q)
      2'b00: begin
        be_mask   = NB'(1) << lane;
        mem_wdata = {NB{wdata_q[7:0]}};
        fmask     = DATA_W'(8'hFF);
        rd_msb    = rd_sh[7];
      end
      2'b01: begin
        be_mask   = NB'(3) << lane;
        mem_wdata = {(NB/2){wdata_q[15:0]}};
        fmask     = DATA_W'(16'hFFFF);
        rd_msb    = rd_sh[15];
      end
      2'b10: begin
        be_mask   = NB'(15) << lane;
        mem_wdata = {(NB/4){wdata_q[31:0]}};
        fmask     = DATA_W'(32'hFFFF_FFFF);
        rd_msb    = rd_sh[31];
      end
      default: begin
        be_mask   = '1;
        mem_wdata = wdata_q;
        fmask     = '1;
        rd_msb    = rd_sh[DATA_W-1];
      end
    endcase
    rd_ext = (rd_sh & fmask) | ((signed_q && rd_msb) ? ~fmask : '0);
  end

  assign mem_addr  = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_be    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_cs = 1'b1;
        mem_we = we_q;
        mem_oe = ~we_q;
        mem_be = be_mask;
        // mem_ready wins over a coincident timeout
        if (mem_ready || timeout) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= 8'd0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wait_cnt <= 8'd0;
            if (req_bad) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            rdata_q <= we_q ? '0 : rd_ext;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl (32-bit and 64-bit instances)
module tb_mem_access_ctrl;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v32 = 1'b0, v64 = 1'b0;
  logic we = 1'b0, sgn = 1'b0, mready = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0, rdata = '0;
  logic sel = 1'b0;

  logic        rr32, rv32, re32, cs32, mw32, oe32;
  logic [31:0] rd32, ma32, wd32;
  logic [3:0]  be32;
  logic        rr64, rv64, re64, cs64, mw64, oe64;
  logic [63:0] rd64, wd64;
  logic [31:0] ma64;
  logic [7:0]  be64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) u32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rr32), .req_we(we), .req_size(size),
    .req_signed(sgn), .req_addr(addr), .req_wdata(wdata[31:0]), .rsp_valid(rv32),
    .rsp_rdata(rd32), .rsp_err(re32), .mem_cs(cs32), .mem_we(mw32), .mem_oe(oe32),
    .mem_addr(ma32), .mem_be(be32), .mem_wdata(wd32), .mem_rdata(rdata[31:0]),
    .mem_ready(mready)
  );

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(64), .MAX_WAIT(MAXW)) u64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rr64), .req_we(we), .req_size(size),
    .req_signed(sgn), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv64),
    .rsp_rdata(rd64), .rsp_err(re64), .mem_cs(cs64), .mem_we(mw64), .mem_oe(oe64),
    .mem_addr(ma64), .mem_be(be64), .mem_wdata(wd64), .mem_rdata(rdata),
    .mem_ready(mready)
  );

  wire        o_ready = sel ? rr64 : rr32;
  wire        o_valid = sel ? rv64 : rv32;
  wire        o_err   = sel ? re64 : re32;
  wire        o_cs    = sel ? cs64 : cs32;
  wire        o_we    = sel ? mw64 : mw32;
  wire        o_oe    = sel ? oe64 : oe32;
  wire [63:0] o_rdata = sel ? rd64 : {32'b0, rd32};
  wire [63:0] o_wdata = sel ? wd64 : {32'b0, wd32};
  wire [63:0] o_addr  = sel ? {32'b0, ma64} : {32'b0, ma32};
  wire [63:0] o_be    = sel ? {56'b0, be64} : {60'b0, be32};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected behaviour from the access rules: natural alignment, lane = addr mod NB,
  // field of 8<<size bits, replication of that field over the bus.
  task automatic model(input int dw, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, output logic err,
                       output logic [63:0] be, output logic [63:0] maddr,
                       output logic [63:0] mwd, output logic [63:0] rdat);
    int nb, bytes, bits, lane;
    logic [63:0] fmask, dmask, f;
    nb    = dw / 8;
    bytes = 1 << sz;
    bits  = 8 * bytes;
    lane  = int'(a % nb);
    err   = (bytes > nb) || ((a % bytes) != 0);
    dmask = (dw == 64) ? '1 : 64'hFFFF_FFFF;
    fmask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    be    = ((64'd1 << bytes) - 64'd1) << lane;
    maddr = {32'b0, a - lane};
    mwd   = '0;
    for (int k = 0; k < dw / bits; k++) mwd = mwd | ((wd & fmask) << (k * bits));
    mwd   = mwd & dmask;
    f     = (rd >> (8 * lane)) & fmask;
    if (sg && f[bits-1]) f = f | ~fmask;
    rdat  = f & dmask;
  endtask

  // One request; nwait = access cycles with mem_ready low before it rises (>= MAXW: timeout).
  task automatic txn(input logic s, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                     input int nwait);
    logic e, done, exp_err;
    logic [63:0] be, maddr, mwd, mrd, exp_rd;
    model(s ? 64 : 32, sz, sg, a, wd, rd, e, be, maddr, mwd, mrd);
    @(negedge clk);
    sel = s;
    chk("req_ready_idle", o_ready, 1);
    we = w; size = sz; sgn = sg; addr = a; wdata = wd;
    if (s) v64 = 1'b1; else v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    if (!e) begin
      done = 1'b0;
      for (int i = 0; i < MAXW && !done; i++) begin
        @(negedge clk);
        chk("acc_cs", o_cs, 1);
        chk("acc_we", o_we, w);
        chk("acc_oe", o_oe, !w);
        chk("acc_be", o_be, be);
        chk("acc_addr", o_addr, maddr);
        chk("acc_wdata", o_wdata, mwd);
        chk("acc_rsp_valid", o_valid, 0);
        chk("acc_req_ready", o_ready, 0);
        mready = (i == nwait);
        rdata  = (i == nwait) ? rd : {$urandom, $urandom};
        @(posedge clk); #1;
        mready = 1'b0;
        if (i == nwait) done = 1'b1;
      end
    end
    exp_err = e || (nwait >= MAXW);
    exp_rd  = (exp_err || w) ? 64'd0 : mrd;
    @(negedge clk);
    chk("resp_valid", o_valid, 1);
    chk("resp_err", o_err, exp_err);
    chk("resp_rdata", o_rdata, exp_rd);
    chk("resp_cs", o_cs, 0);
    chk("resp_be", o_be, 0);
    @(negedge clk);
    chk("post_valid", o_valid, 0);
    chk("post_ready", o_ready, 1);
    chk("hold_rdata", o_rdata, exp_rd);
    chk("hold_err", o_err, exp_err);
  endtask

  task automatic chk_reset_state(input logic s);
    sel = s;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_cs", o_cs, 0);
    chk("rst_we", o_we, 0);
    chk("rst_oe", o_oe, 0);
    chk("rst_be", o_be, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_wdata", o_wdata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state(1'b0);
    chk_reset_state(1'b1);
    rst = 1'b0;

    // Signed byte read at lane 3, halfword write, misaligned and illegal-size requests
    txn(0, 0, 2'b00, 1, 32'h103, 64'd0, 64'h80AABBCC, 0);
    txn(0, 1, 2'b01, 0, 32'h202, 64'h0000BEEF, 64'd0, 0);
    txn(0, 0, 2'b10, 0, 32'h101, 64'd0, 64'h11223344, 0);
    txn(0, 0, 2'b11, 0, 32'h100, 64'd0, 64'h11223344, 0);
    // Timeout with mem_ready never high, then mem_ready on the last allowed cycle
    txn(0, 0, 2'b10, 0, 32'h300, 64'd0, 64'hCAFEF00D, MAXW);
    txn(0, 0, 2'b10, 0, 32'h300, 64'd0, 64'hCAFEF00D, MAXW - 1);
    // 64-bit bus: halfword at lane 6, doubleword pass-through, signed word
    txn(1, 0, 2'b01, 0, 32'h00E, 64'd0, 64'h1234_0000_0000_0000, 0);
    txn(1, 1, 2'b11, 0, 32'h018, 64'h0123_4567_89AB_CDEF, 64'd0, 1);
    txn(1, 0, 2'b10, 1, 32'h024, 64'd0, 64'h9876_5432_0000_0000, 2);
    txn(1, 0, 2'b11, 0, 32'h01C, 64'd0, 64'd0, 0);

    // mem_ready outside ACCESS must not start or end anything
    @(negedge clk);
    sel = 1'b0;
    mready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready_ign_valid", o_valid, 0);
      chk("idle_ready_ign_cs", o_cs, 0);
      chk("idle_ready_ign_rdy", o_ready, 1);
    end
    mready = 1'b0;

    // Reset in the second ACCESS cycle drops the access with no response
    txn(0, 0, 2'b00, 1, 32'h103, 64'd0, 64'h80AABBCC, 0);
    @(negedge clk);
    sel = 1'b0; we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h400; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    @(negedge clk);
    chk("mid_acc1_cs", o_cs, 1);
    @(negedge clk);
    chk("mid_acc2_cs", o_cs, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state(1'b0);
    @(negedge clk);
    chk("after_rst_no_rsp", o_valid, 0);
    txn(0, 0, 2'b01, 1, 32'h402, 64'd0, 64'hFF80_0000, 0);

    // Randomized traffic on both instances
    for (int n = 0; n < 60; n++) begin
      rs = 2'($urandom_range(0, 3));
      ra = {20'b0, 12'($urandom)};
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
      txn(1'($urandom), 1'($urandom), rs, 1'($urandom), ra, {$urandom, $urandom},
          {$urandom, $urandom}, $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
